// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES-style 4021 gamepad once per frame and presents filtered button levels.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   i_pad_data      serial pad data, active-low, asynchronous to clk
//   o_pad_latch     parallel-load strobe to the pad
//   o_pad_clk       shift clock to the pad (pad shifts on its rising edge)
//   o_buttons       filtered buttons, active-high: A,B,Sel,Start,Up,Down,Left,Right (bit 0..7)
//   o_pressed       rising-edge flags of o_buttons, nonzero only while o_valid is high
//   o_valid         one-cycle pulse at the end of every poll
//   o_present       pad detected on the last poll
//   o_up/o_down/o_left/o_right/o_pause/o_restart  single-button views of o_buttons
module nes_pad_reader #(
    parameter int HALF_PERIOD = 150,
    parameter int POLL_PERIOD = 420000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pad_data,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    output logic [7:0] o_buttons,
    output logic [7:0] o_pressed,
    output logic       o_valid,
    output logic       o_present,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_pause,
    output logic       o_restart
);
    localparam int CW = $clog2(POLL_PERIOD);
    localparam int PW = $clog2(2 * HALF_PERIOD);

    typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t          state, state_nx;
    logic [1:0]      sync;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ph;
    logic [2:0]      idx;
    logic [7:0]      raw, hist;
    logic            poll_wrap, ph_last, stuck, agree;

    assign poll_wrap = cnt == CW'(POLL_PERIOD - 1);
    assign ph_last   = ph == (state == LATCH ? PW'(2 * HALF_PERIOD - 1) : PW'(HALF_PERIOD - 1));
    // All eight bits reading as pressed means the data line is held low: no pad plugged in.
    assign stuck     = raw == 8'hFF;
    assign agree     = raw == hist;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = poll_wrap ? LATCH : IDLE;
            LATCH:    state_nx = ph_last ? SHIFT_LO : LATCH;
            SHIFT_LO: state_nx = ph_last ? (idx == 3'd7 ? DONE : SHIFT_HI) : SHIFT_LO;
            SHIFT_HI: state_nx = ph_last ? SHIFT_LO : SHIFT_HI;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            cnt         <= '0;
            ph          <= '0;
            idx         <= '0;
            raw         <= '0;
            hist        <= '0;
            o_pad_latch <= 1'b0;
            o_pad_clk   <= 1'b0;
            o_buttons   <= '0;
            o_pressed   <= '0;
            o_valid     <= 1'b0;
            o_present   <= 1'b0;
        end else begin
            sync        <= {sync[0], i_pad_data};
            cnt         <= poll_wrap ? '0 : cnt + 1'b1;
            ph          <= (state_nx != state || state == IDLE) ? '0 : ph + 1'b1;
            idx         <= state == LATCH ? '0 : (state == SHIFT_HI && ph_last) ? idx + 1'b1 : idx;
            // Pad lines are registered from the next state so they stay glitch-free and track the FSM.
            o_pad_latch <= state_nx == LATCH;
            o_pad_clk   <= state_nx == SHIFT_HI;
            o_valid     <= state == DONE;
            o_pressed   <= '0;
            if (state == SHIFT_LO && ph_last)
                raw[idx] <= ~sync[1];
            if (state == DONE) begin
                hist      <= stuck ? '0 : raw;
                o_present <= !stuck;
                if (stuck)
                    o_buttons <= '0;
                else if (agree) begin
                    o_buttons <= raw;
                    o_pressed <= raw & ~o_buttons;
                end
            end
        end
    end

    assign o_up      = o_buttons[4];
    assign o_down    = o_buttons[5];
    assign o_left    = o_buttons[6];
    assign o_right   = o_buttons[7];
    assign o_pause   = o_buttons[3];
    assign o_restart = o_buttons[2];
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: drives nes_pad_reader from a behavioural 4021 pad and checks polls against a reference model.
module tb_nes_pad_reader;
    localparam int H = 4;
    localparam int P = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_pad_data;
    logic       o_pad_latch, o_pad_clk, o_valid, o_present;
    logic       o_up, o_down, o_left, o_right, o_pause, o_restart;
    logic [7:0] o_buttons, o_pressed;

    nes_pad_reader #(.HALF_PERIOD(H), .POLL_PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .i_pad_data(i_pad_data),
        .o_pad_latch(o_pad_latch), .o_pad_clk(o_pad_clk),
        .o_buttons(o_buttons), .o_pressed(o_pressed), .o_valid(o_valid), .o_present(o_present),
        .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
        .o_pause(o_pause), .o_restart(o_restart)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // 4021 model: parallel load while latch is high, shift toward bit 0 on each pad_clk rise.
    logic [7:0] pad_bits = 8'hFF;
    logic       stuck = 1'b0;
    logic [7:0] sr = 8'hFF;
    logic       pclk_d = 1'b0;
    always @(negedge clk) begin
        if (o_pad_latch)
            sr = pad_bits;
        else if (o_pad_clk && !pclk_d)
            sr = {1'b1, sr[7:1]};
        pclk_d = o_pad_clk;
    end
    assign i_pad_data = ~stuck & sr[0];

    int bad_pressed = 0;
    always @(negedge clk)
        if (rst_n && o_valid === 1'b0 && o_pressed !== 8'h00) bad_pressed++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int p_latch_cyc, p_latch_len, p_rises, p_min_hi, p_max_hi, p_valid_cyc;
    bit p_overlap, p_timeout;
    logic [7:0] v_buttons, v_pressed;
    logic [5:0] v_dirs;
    logic       v_present;

    task automatic run_poll();
        bit seen = 0;
        int hi = 0;
        p_latch_len = 0; p_rises = 0; p_min_hi = 999; p_max_hi = 0;
        p_overlap = 0; p_timeout = 1; p_latch_cyc = -1; p_valid_cyc = -1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (o_pad_latch && !seen) begin seen = 1; p_latch_cyc = cyc; end
            if (o_pad_latch) p_latch_len++;
            if (o_pad_latch && o_pad_clk) p_overlap = 1;
            if (o_pad_clk) hi++;
            else if (hi > 0) begin
                p_rises++;
                p_min_hi = hi < p_min_hi ? hi : p_min_hi;
                p_max_hi = hi > p_max_hi ? hi : p_max_hi;
                hi = 0;
            end
            if (o_valid) begin
                p_timeout   = 0;
                p_valid_cyc = cyc;
                v_buttons   = o_buttons;
                v_pressed   = o_pressed;
                v_present   = o_present;
                v_dirs      = {o_right, o_left, o_down, o_up, o_pause, o_restart};
                break;
            end
        end
        chk("poll_timeout", 32'(p_timeout), 0);
    endtask

    function automatic logic [5:0] dirs_of(input logic [7:0] b);
        return {b[7], b[6], b[5], b[4], b[3], b[2]};
    endfunction

    typedef struct {
        logic [7:0] pad;
        bit         st;
        logic [7:0] buttons;
        bit         present;
        logic [7:0] pressed;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] pad, input bit st, input logic [7:0] b,
                                input bit pr, input logic [7:0] p);
        vec_t v;
        v.pad = pad; v.st = st; v.buttons = b; v.present = pr; v.pressed = p;
        return v;
    endfunction

    function automatic vec_t rnd_dummy();
        return mk(8'hFF, 0, 8'h00, 1, 8'h00);
    endfunction

    vec_t vecs[$];
    logic [7:0] m_buttons, m_hist, m_pressed, m_raw, prev_pad, one;
    bit         m_present;
    int         r;

    initial begin
        vecs.push_back(mk(8'hEF, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hEF, 0, 8'h10, 1, 8'h10));
        vecs.push_back(mk(8'hEF, 0, 8'h10, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h10, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h08, 1, 8'h08));
        vecs.push_back(mk(8'hF7, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(8'hF7, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h08, 1, 8'h08));
        vecs.push_back(mk(8'hFF, 0, 8'h08, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 0, 8'h00, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 0, 8'h00, 1, 8'h00));
        for (int i = 0; i < 8; i++) begin
            one = 8'h01 << i;
            vecs.push_back(mk(~one, 0, one >> 1, 1, 8'h00));
            vecs.push_back(mk(~one, 0, one, 1, one));
        end
        vecs.push_back(mk(8'h01, 0, 8'h80, 1, 8'h00));
        vecs.push_back(mk(8'h01, 0, 8'hFE, 1, 8'h7E));

        repeat (3) @(negedge clk);
        chk("rst_latch", 32'(o_pad_latch), 0);
        chk("rst_padclk", 32'(o_pad_clk), 0);
        chk("rst_buttons", 32'(o_buttons), 0);
        chk("rst_present", 32'(o_present), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_pressed", 32'(o_pressed), 0);
        rst_n = 1'b1;

        run_poll();
        chk("first_latch_cycle", 32'(p_latch_cyc), P);
        chk("latch_len", 32'(p_latch_len), 2 * H);
        chk("valid_cycle", 32'(p_valid_cyc), P + 17 * H + 1);
        chk("padclk_rises", 32'(p_rises), 7);
        chk("padclk_min_high", 32'(p_min_hi), H);
        chk("padclk_max_high", 32'(p_max_hi), H);
        chk("latch_clk_overlap", 32'(p_overlap), 0);
        chk("idle_present", 32'(v_present), 1);
        chk("idle_buttons", 32'(v_buttons), 0);

        foreach (vecs[k]) begin
            pad_bits = vecs[k].pad;
            stuck    = vecs[k].st;
            run_poll();
            chk($sformatf("vec%0d_buttons", k), 32'(v_buttons), 32'(vecs[k].buttons));
            chk($sformatf("vec%0d_present", k), 32'(v_present), 32'(vecs[k].present));
            chk($sformatf("vec%0d_pressed", k), 32'(v_pressed), 32'(vecs[k].pressed));
            chk($sformatf("vec%0d_dirs", k), 32'(v_dirs), 32'(dirs_of(vecs[k].buttons)));
            chk($sformatf("vec%0d_rises", k), 32'(p_rises), 7);
        end

        m_buttons = 8'hFE; m_hist = 8'hFE; m_present = 1; prev_pad = 8'h01;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            stuck    = r < 15;
            pad_bits = r < 60 ? prev_pad : 8'($urandom);
            prev_pad = pad_bits;
            m_raw = stuck ? 8'hFF : ~pad_bits;
            m_pressed = 8'h00;
            if (m_raw == 8'hFF) begin
                m_present = 0; m_buttons = 8'h00; m_hist = 8'h00;
            end else begin
                m_present = 1;
                if (m_raw == m_hist) begin
                    m_pressed = m_raw & ~m_buttons;
                    m_buttons = m_raw;
                end
                m_hist = m_raw;
            end
            run_poll();
            chk($sformatf("rnd%0d_buttons", n), 32'(v_buttons), 32'(m_buttons));
            chk($sformatf("rnd%0d_present", n), 32'(v_present), 32'(m_present));
            chk($sformatf("rnd%0d_pressed", n), 32'(v_pressed), 32'(m_pressed));
            chk($sformatf("rnd%0d_dirs", n), 32'(v_dirs), 32'(dirs_of(m_buttons)));
        end

        stuck = 0; pad_bits = 8'h01;
        run_poll();
        run_poll();
        chk("pre_reset_buttons", 32'(o_buttons), 32'hFE);
        begin
            int rises = 0;
            bit pd = 0;
            for (int t = 0; t < 400 && rises < 4; t++) begin
                @(negedge clk);
                if (o_pad_clk && !pd) rises++;
                pd = o_pad_clk;
            end
            chk("reach_shift_hi3", 32'(rises), 4);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_latch", 32'(o_pad_latch), 0);
        chk("midrst_padclk", 32'(o_pad_clk), 0);
        chk("midrst_buttons", 32'(o_buttons), 0);
        chk("midrst_present", 32'(o_present), 0);
        chk("midrst_valid", 32'(o_valid), 0);
        chk("midrst_dirs", 32'({o_right, o_left, o_down, o_up, o_pause, o_restart}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pad_bits = 8'hFF;
        run_poll();
        chk("postrst_latch_cycle", 32'(p_latch_cyc), P);
        chk("postrst_valid_cycle", 32'(p_valid_cyc), P + 17 * H + 1);
        chk("postrst_present", 32'(v_present), 1);
        chk("postrst_buttons", 32'(v_buttons), 0);

        chk("pressed_outside_valid", 32'(bad_pressed), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
